axi_read_master: RTL and testbench
==================================

// Module: axi_read_master
// PURPOSE
// AXI4 read-burst master; drives the AR channel and consumes the R channel of axi_slave_ram.
// - Accepts one request (address, burst length) on a valid/ready port and issues one INCR burst.
// - Forwards returned beats on a registered valid/ready output stream, with last and response per beat.
// - Checks the slave's rlast and rresp against the expected burst and reports errors in sticky flags.
// PARAMETERS
// ADDRESS_WIDTH  8   width of req_addr and araddr
// DATA_WIDTH     32  width of rdata and out_data
// BEAT_SIZE      2   value driven on arsize (log2 bytes per beat); must be <= log2(DATA_WIDTH/8)
// PORTS
// aclk       in   1      clock; all logic on rising edge
// areset     in   1      synchronous, active-high reset
// req_valid  in   1      request valid
// req_ready  out  1      request accepted when req_valid && req_ready
// req_addr   in   AW     burst start address
// req_len    in   8      beats minus 1 (AXI arlen encoding)
// araddr     out  AW     AR address
// arlen      out  8      AR burst length
// arsize     out  3      constant BEAT_SIZE
// arburst    out  2      constant 2'b01 (INCR)
// arvalid    out  1      AR valid
// arready    in   1      AR ready
// rdata      in   DW     R data
// rresp      in   2      R response
// rlast      in   1      R last
// rvalid     in   1      R valid
// rready     out  1      R ready
// out_data   out  DW     beat data
// out_resp   out  2      beat response (rresp as received)
// out_last   out  1      final beat of burst, by this block's beat count
// out_valid  out  1      output beat valid
// out_ready  in   1      downstream ready
// busy       out  1      high in ADDR or DATA, or while output buffer non-empty
// resp_err   out  1      sticky: some beat had rresp != 2'b00
// last_err   out  1      sticky: rlast disagreed with expected last on some beat
// BEHAVIOUR
// - Reset (areset high at an edge): state IDLE; arvalid, rready, out_valid, busy, resp_err, last_err,
//   beat_cnt = 0; araddr, arlen = 0; output buffer emptied. req_ready = 0 while areset is high.
// - Reset mid-burst aborts immediately; in-flight R beats are dropped. The slave must be reset with it.
// - FSM IDLE -> ADDR -> DATA -> IDLE.
//   IDLE: req_ready = 1 (combinational on state). On req_valid && req_ready: latch araddr <= req_addr,
//     arlen <= req_len, clear resp_err/last_err, arvalid <= 1, go ADDR. arvalid rises the cycle after accept.
//   ADDR: araddr/arlen/arsize/arburst/arvalid held stable until arvalid && arready. On that edge:
//     arvalid <= 0, beat_cnt <= 0, go DATA. arready high with arvalid low is ignored.
//   DATA: rready = buffer in_ready (registered, never depends combinationally on out_ready).
//     Each rvalid && rready: push {rdata, rresp, beat_cnt == arlen}; beat_cnt++.
//     rresp != 0 -> resp_err <= 1. rlast != (beat_cnt == arlen) -> last_err <= 1.
//     Burst ends by count only: handshake with beat_cnt == arlen -> go IDLE, rready drops next cycle.
//     Early rlast is flagged, not acted on; beats after the count are never accepted (rready = 0 outside DATA).
// - arlen 0 = 1 beat; arlen 255 = 256 beats; beat_cnt is 8 bits and stops at equality (no wrap).
// - Latency: beat is presented on out_* the cycle after its R handshake when buffer empty.
// - Output buffer: full throughput, one beat per cycle under continuous rvalid/out_ready.
//   out_* stable while out_valid && !out_ready. Stalls back-pressure R only via rready.
// - A new request may be accepted in IDLE while the buffer still drains; order is preserved.
// STRUCTURE
// - Shared package axi_pkg: AXI_BURST_INCR = 2'b01, AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR, FSM state enum.
// - Sub-module axi_skid_buffer #(WIDTH = DW+3): 2-entry skid buffer, registered in_ready and out_valid.
// - Top: FSM, AR registers, beat counter, sticky flags; roughly 200 lines total.
// TESTING
// - Reset: hold areset 3 cycles with R/AR driven high -> arvalid=rready=out_valid=0, req_ready=0 then 1 after release.
// - req_addr=0x10, req_len=4, arready delayed 3 cycles -> araddr=0x10 arlen=4 arsize=2 arburst=1 held; 5 beats out,
//   out_last only on 5th, no errors.
// - req_len=0 with slave rlast on beat 1 -> single beat, out_last=1, FSM returns IDLE, busy low once drained.
// - out_ready toggled 1/0 every cycle over 8-beat burst -> all 8 beats out in order, none lost or duplicated.
// - Beat 3 of 5 has rresp=2'b10, rlast asserted on beat 2 -> resp_err=1, last_err=1, still 5 beats;
//   both flags clear on next accepted request.
// - areset asserted on beat 2 of 8 -> all outputs at reset values next cycle; next request completes normally.

Source files
------------

// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI encodings and read-master state type
package axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

endpackage

// File: rtl/axi_skid_buffer.sv
// rtl/axi_skid_buffer.sv - 2-entry skid buffer with registered s_tready and m_tvalid
module axi_skid_buffer #(
    parameter int WIDTH = 35
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic [WIDTH-1:0] s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    output logic [WIDTH-1:0] m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready
);

    logic [WIDTH-1:0] skid_data;
    logic             skid_valid;
    logic             s_fire;
    logic             m_free;

    assign s_fire = s_tvalid && s_tready;
    assign m_free = !m_tvalid || m_tready;

    // The skid slot only fills when the output is stalled; s_tready is simply its inverse, registered.
    always_ff @(posedge aclk) begin
        if (areset) begin
            m_tvalid   <= 1'b0;
            m_tdata    <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            s_tready   <= 1'b1;
        end else begin
            if (m_free) begin
                if (skid_valid) begin
                    m_tdata    <= skid_data;
                    m_tvalid   <= 1'b1;
                    skid_valid <= 1'b0;
                    s_tready   <= 1'b1;
                end else begin
                    m_tvalid <= s_fire;
                    if (s_fire) begin
                        m_tdata <= s_tdata;
                    end
                end
            end else if (s_fire) begin
                skid_data  <= s_tdata;
                skid_valid <= 1'b1;
                s_tready   <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/axi_read_master.sv
// rtl/axi_read_master.sv - AXI4 INCR read-burst master with buffered beat output and sticky checks
module axi_read_master
    import axi_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int BEAT_SIZE     = 2
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [7:0]               req_len,
    output logic [ADDRESS_WIDTH-1:0] araddr,
    output logic [7:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [DATA_WIDTH-1:0]    rdata,
    input  logic [1:0]               rresp,
    input  logic                     rlast,
    input  logic                     rvalid,
    output logic                     rready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [1:0]               out_resp,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     resp_err,
    output logic                     last_err
);

    localparam int BUF_W = DATA_WIDTH + 3;

    state_t           state;
    state_t           state_next;
    logic [7:0]       beat_cnt;
    logic             beat_is_last;
    logic             req_fire;
    logic             ar_fire;
    logic             r_fire;
    logic             buf_s_tvalid;
    logic             buf_s_tready;
    logic [BUF_W-1:0] buf_s_tdata;
    logic [BUF_W-1:0] buf_m_tdata;
    logic             buf_m_tvalid;

    assign req_ready    = (state == ST_IDLE) && !areset;
    assign req_fire     = req_valid && req_ready;
    assign ar_fire      = arvalid && arready;
    assign rready       = (state == ST_DATA) && buf_s_tready;
    assign r_fire       = rvalid && rready;
    assign beat_is_last = (beat_cnt == arlen);

    assign arsize  = 3'(BEAT_SIZE);
    assign arburst = AXI_BURST_INCR;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The burst ends on our own beat count; the slave's rlast is only checked, never obeyed.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (req_fire) state_next = ST_ADDR;
            ST_ADDR: if (ar_fire) state_next = ST_DATA;
            ST_DATA: if (r_fire && beat_is_last) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            araddr   <= '0;
            arlen    <= '0;
            arvalid  <= 1'b0;
            beat_cnt <= '0;
            resp_err <= 1'b0;
            last_err <= 1'b0;
        end else begin
            if (req_fire) begin
                araddr   <= req_addr;
                arlen    <= req_len;
                arvalid  <= 1'b1;
                resp_err <= 1'b0;
                last_err <= 1'b0;
            end
            if (state == ST_ADDR && ar_fire) begin
                arvalid  <= 1'b0;
                beat_cnt <= '0;
            end
            if (r_fire) begin
                if (!beat_is_last) begin
                    beat_cnt <= beat_cnt + 8'd1;
                end
                if (rresp != AXI_RESP_OKAY) begin
                    resp_err <= 1'b1;
                end
                if (rlast != beat_is_last) begin
                    last_err <= 1'b1;
                end
            end
        end
    end

    assign buf_s_tvalid = rvalid && (state == ST_DATA);
    assign buf_s_tdata  = {rdata, rresp, beat_is_last};

    axi_skid_buffer #(
        .WIDTH(BUF_W)
    ) u_out_buf (
        .aclk    (aclk),
        .areset  (areset),
        .s_tdata (buf_s_tdata),
        .s_tvalid(buf_s_tvalid),
        .s_tready(buf_s_tready),
        .m_tdata (buf_m_tdata),
        .m_tvalid(buf_m_tvalid),
        .m_tready(out_ready)
    );

    assign out_data  = buf_m_tdata[BUF_W-1:3];
    assign out_resp  = buf_m_tdata[2:1];
    assign out_last  = buf_m_tdata[0];
    assign out_valid = buf_m_tvalid;

    // The skid slot can only be occupied while m_tvalid is high, so out_valid covers buffer occupancy.
    assign busy = (state != ST_IDLE) || buf_m_tvalid;

endmodule

// File: tb/tb_axi_read_master.sv
// tb/tb_axi_read_master.sv - self-checking bench for axi_read_master
module tb_axi_read_master;

    logic        aclk;
    logic        areset;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_addr;
    logic [7:0]  req_len;
    logic [7:0]  araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [31:0] out_data;
    logic [1:0]  out_resp;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        resp_err;
    logic        last_err;

    axi_read_master #(
        .ADDRESS_WIDTH(8),
        .DATA_WIDTH   (32),
        .BEAT_SIZE    (2)
    ) dut (
        .aclk     (aclk),
        .areset   (areset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .req_len  (req_len),
        .araddr   (araddr),
        .arlen    (arlen),
        .arsize   (arsize),
        .arburst  (arburst),
        .arvalid  (arvalid),
        .arready  (arready),
        .rdata    (rdata),
        .rresp    (rresp),
        .rlast    (rlast),
        .rvalid   (rvalid),
        .rready   (rready),
        .out_data (out_data),
        .out_resp (out_resp),
        .out_last (out_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .resp_err (resp_err),
        .last_err (last_err)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] len;
        int         ar_delay;
        int         err_beat;
        int         last_beat;
        int         mode;
        logic       exp_re;
        logic       exp_le;
    } vec_t;

    beat_t sb[$];
    vec_t  vecs[7];
    int    errors = 0;
    int    checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] beat_data(input logic [7:0] addr, input int i);
        logic [7:0] b;
        b = 8'(i);
        return {8'hA5, addr, b, b ^ 8'h3C};
    endfunction

    // mode 0: out_ready always high, 1: toggles every cycle, 2: random ready and rvalid gaps
    task automatic run_burst(input logic [7:0] addr, input logic [7:0] len, input int ar_delay,
                             input int err_beat, input int last_beat, input int mode,
                             input logic exp_re, input logic exp_le);
        int    nb;
        int    ar_wait;
        bit    ar_done;
        bit    held_bad;
        int    r_idx;
        int    out_cnt;
        int    cyc;
        int    first_c;
        int    last_c;
        beat_t e;
        nb = int'(len) + 1;
        for (int i = 0; i < nb; i++) begin
            e.data = beat_data(addr, i);
            e.resp = (i == err_beat) ? 2'b10 : 2'b00;
            e.last = (i == nb - 1);
            sb.push_back(e);
        end
        req_addr  = addr;
        req_len   = len;
        req_valid = 1'b1;
        chk("req_ready_idle", req_ready, 1);
        @(posedge aclk);
        @(negedge aclk);
        req_valid = 1'b0;
        chk("arvalid_rise", arvalid, 1);
        chk("flags_clear_on_accept", {resp_err, last_err}, 0);
        ar_wait  = 0;
        ar_done  = 0;
        held_bad = 0;
        r_idx    = 0;
        out_cnt  = 0;
        cyc      = 0;
        first_c  = -1;
        last_c   = -1;
        while (cyc < 3000 && !(out_cnt == nb && !busy)) begin
            if (ar_done && r_idx < nb) begin
                rvalid = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
                rdata  = beat_data(addr, r_idx);
                rresp  = (r_idx == err_beat) ? 2'b10 : 2'b00;
                rlast  = (last_beat >= 0) ? (r_idx == last_beat) : (r_idx == nb - 1);
                if (rvalid && rready) r_idx++;
            end else begin
                rvalid = 1'b0;
                rresp  = 2'b00;
                rlast  = 1'b0;
            end
            if (!ar_done && arvalid) begin
                if (araddr !== addr || arlen !== len || arsize !== 3'd2 || arburst !== 2'b01)
                    held_bad = 1;
                arready = (ar_wait >= ar_delay);
                if (arready) ar_done = 1;
                ar_wait++;
            end else begin
                arready = 1'b0;
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = cyc[0];
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_beat", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("beat", {out_data, out_resp, out_last}, {e.data, e.resp, e.last});
                end
                if (first_c < 0) first_c = cyc;
                last_c = cyc;
                out_cnt++;
            end
            @(posedge aclk);
            @(negedge aclk);
            cyc++;
        end
        rvalid    = 1'b0;
        rlast     = 1'b0;
        arready   = 1'b0;
        out_ready = 1'b0;
        chk("burst_timeout", cyc < 3000, 1);
        chk("ar_fields_held", held_bad, 0);
        chk("ar_handshake", ar_done, 1);
        chk("beat_count", out_cnt, nb);
        if (mode == 0) chk("throughput", last_c - first_c, nb - 1);
        chk("resp_err", resp_err, exp_re);
        chk("last_err", last_err, exp_le);
        chk("busy_drained", busy, 0);
        chk("sb_empty", sb.size(), 0);
    endtask

    initial begin
        int n;
        int guard;
        vecs[0] = '{8'h10, 8'd4,   3, -1, -1, 0, 1'b0, 1'b0};
        vecs[1] = '{8'h20, 8'd0,   0, -1,  0, 0, 1'b0, 1'b0};
        vecs[2] = '{8'h40, 8'd7,   1, -1, -1, 1, 1'b0, 1'b0};
        vecs[3] = '{8'h80, 8'd4,   0,  2,  1, 0, 1'b1, 1'b1};
        vecs[4] = '{8'h90, 8'd2,   2, -1, -1, 0, 1'b0, 1'b0};
        vecs[5] = '{8'h00, 8'd255, 0, -1, -1, 0, 1'b0, 1'b0};
        vecs[6] = '{8'hC4, 8'd255, 4, 17, -1, 2, 1'b1, 1'b0};

        areset    = 1'b1;
        req_valid = 1'b0;
        req_addr  = 8'h00;
        req_len   = 8'h00;
        arready   = 1'b1;
        rvalid    = 1'b1;
        rlast     = 1'b1;
        rresp     = 2'b00;
        rdata     = 32'hFFFF_FFFF;
        out_ready = 1'b1;
        repeat (3) begin
            @(posedge aclk);
            @(negedge aclk);
            chk("rst_req_ready", req_ready, 0);
        end
        chk("rst_outputs", {arvalid, rready, out_valid, busy, resp_err, last_err}, 0);
        chk("rst_ar_regs", {araddr, arlen}, 0);
        areset  = 1'b0;
        arready = 1'b0;
        rvalid  = 1'b0;
        rlast   = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        chk("post_rst_req_ready", req_ready, 1);
        chk("post_rst_idle", {arvalid, busy}, 0);

        for (int v = 0; v < 7; v++) begin
            run_burst(vecs[v].addr, vecs[v].len, vecs[v].ar_delay, vecs[v].err_beat,
                      vecs[v].last_beat, vecs[v].mode, vecs[v].exp_re, vecs[v].exp_le);
        end

        // Reset arrives after the second beat of an 8-beat burst has been taken.
        req_addr  = 8'h55;
        req_len   = 8'd7;
        req_valid = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        req_valid = 1'b0;
        arready   = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        arready   = 1'b0;
        out_ready = 1'b1;
        n = 0;
        guard = 0;
        while (n < 2 && guard < 50) begin
            rvalid = 1'b1;
            rdata  = beat_data(8'h55, n);
            rresp  = 2'b00;
            rlast  = 1'b0;
            if (rready) n++;
            @(posedge aclk);
            @(negedge aclk);
            guard++;
        end
        chk("midrst_beats_taken", n, 2);
        areset = 1'b1;
        rdata  = beat_data(8'h55, 2);
        @(posedge aclk);
        @(negedge aclk);
        chk("midrst_outputs", {arvalid, rready, out_valid, busy, resp_err, last_err, req_ready}, 0);
        chk("midrst_ar_regs", {araddr, arlen}, 0);
        areset    = 1'b0;
        rvalid    = 1'b0;
        out_ready = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        chk("midrst_out_idle", {out_valid, busy}, 0);
        run_burst(8'h33, 8'd5, 1, -1, -1, 0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
